// File: rtl/nibbler_pkg.sv
// nibbler_pkg
// Shared definitions for the nibble-wide datapath blocks.
//   NIBBLE_W    : default data width of a nibble register.
//   reg_mode_t  : 3-bit operation select for universal_register.
//   to_reg_mode : maps a raw 3-bit mode bus onto reg_mode_t.
package nibbler_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_CLEAR = 3'b010,
        MODE_INC   = 3'b011,
        MODE_DEC   = 3'b100,
        MODE_SHL   = 3'b101,
        MODE_SHR   = 3'b110,
        MODE_ROL   = 3'b111
    } reg_mode_t;

    // All eight codes are defined, so the cast never yields an
    // out-of-range enum value.
    function automatic reg_mode_t to_reg_mode(input logic [2:0] raw);
        return reg_mode_t'(raw);
    endfunction

endpackage : nibbler_pkg

// File: rtl/universal_register_next.sv
// universal_register_next
// Purely combinational next-state and carry logic for universal_register.
// Ports:
//   en        : operation enable; low selects the current state.
//   mode      : operation select (reg_mode_t).
//   q         : current register contents.
//   cout      : current carry/borrow/shifted-out flag.
//   d         : parallel load data.
//   sin       : serial input for SHL/SHR.
//   q_next    : value q takes on the next rising edge.
//   cout_next : value cout takes on the next rising edge.
module universal_register_next
    import nibbler_pkg::*;
#(
    parameter int WIDTH = NIBBLE_W
) (
    input  logic             en,
    input  reg_mode_t        mode,
    input  logic [WIDTH-1:0] q,
    input  logic             cout,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q_next,
    output logic             cout_next
);

    // Every operation is formed WIDTH+1 bits wide so the flag bit falls
    // out of the same vector as the result. Building shifts this way also
    // keeps WIDTH = 1 legal: there is never a q[WIDTH-2:0] slice.
    logic [WIDTH:0] one_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic [WIDTH:0] shl_ext;
    logic [WIDTH:0] shr_ext;
    logic [WIDTH:0] rol_ext;

    assign one_ext = {{WIDTH{1'b0}}, 1'b1};

    // Carry out of the top bit on wrap from all-ones.
    assign inc_ext = {1'b0, q} + one_ext;

    // Bit WIDTH becomes 1 only when q was 0 (borrow).
    assign dec_ext = {1'b0, q} - one_ext;

    // [WIDTH] = bit shifted out, [WIDTH-1:0] = new contents.
    assign shl_ext = {q, sin};

    // [WIDTH:1] = new contents, [0] = bit shifted out.
    assign shr_ext = {sin, q};

    // Same layout as SHL, with the old MSB fed back in place of sin.
    assign rol_ext = {q, q[WIDTH-1]};

    always_comb begin
        q_next    = q;
        cout_next = cout;
        if (en) begin
            unique case (mode)
                MODE_HOLD: begin
                    q_next    = q;
                    cout_next = cout;
                end
                MODE_LOAD: begin
                    q_next    = d;
                    cout_next = 1'b0;
                end
                MODE_CLEAR: begin
                    q_next    = '0;
                    cout_next = 1'b0;
                end
                MODE_INC: begin
                    q_next    = inc_ext[WIDTH-1:0];
                    cout_next = inc_ext[WIDTH];
                end
                MODE_DEC: begin
                    q_next    = dec_ext[WIDTH-1:0];
                    cout_next = dec_ext[WIDTH];
                end
                MODE_SHL: begin
                    q_next    = shl_ext[WIDTH-1:0];
                    cout_next = shl_ext[WIDTH];
                end
                MODE_SHR: begin
                    q_next    = shr_ext[WIDTH:1];
                    cout_next = shr_ext[0];
                end
                MODE_ROL: begin
                    q_next    = rol_ext[WIDTH-1:0];
                    cout_next = rol_ext[WIDTH];
                end
                default: begin
                    q_next    = q;
                    cout_next = cout;
                end
            endcase
        end
    end

endmodule : universal_register_next

// File: rtl/universal_register.sv
// universal_register
// WIDTH-bit universal register: hold, load, clear, increment, decrement,
// shift left/right with serial input, and rotate left, with a registered
// carry/borrow/shifted-out flag.
// Ports:
//   clk   : clock; all state updates on its rising edge.
//   reset : asynchronous active-high reset; q <= RESET_VALUE, cout <= 0.
//   en    : operation enable; low holds q and cout.
//   mode  : operation select, see nibbler_pkg::reg_mode_t.
//   d     : parallel load data.
//   sin   : serial input for SHL/SHR.
//   q     : register contents.
//   cout  : registered carry/borrow/shifted-out bit.
//   zero  : high when q == 0 (decoded from q only).
module universal_register
    import nibbler_pkg::*;
#(
    parameter int               WIDTH       = NIBBLE_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             zero
);

    reg_mode_t        mode_e;
    logic [WIDTH-1:0] q_next;
    logic             cout_next;

    assign mode_e = to_reg_mode(mode);

    universal_register_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .en        (en),
        .mode      (mode_e),
        .q         (q),
        .cout      (cout),
        .d         (d),
        .sin       (sin),
        .q_next    (q_next),
        .cout_next (cout_next)
    );

    // Only state in the block. Reset clears cout as well, so a carry
    // produced just before reset never survives it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= RESET_VALUE;
            cout <= 1'b0;
        end else begin
            q    <= q_next;
            cout <= cout_next;
        end
    end

    // Decoded from the register alone, never from same-cycle inputs.
    assign zero = (q == '0);

endmodule : universal_register

// File: tb/tb_universal_register.sv
// tb_universal_register
// Directed bench for universal_register. dut0 uses the default
// RESET_VALUE (0); dut1 uses RESET_VALUE = 4'h7. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_universal_register;
    import nibbler_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst0, en0, sin0, cout0, zero0;
    logic [2:0]   mode0;
    logic [W-1:0] d0, q0;
    logic         rst1, en1, sin1, cout1, zero1;
    logic [2:0]   mode1;
    logic [W-1:0] d1, q1;

    int tests;
    int failed;

    universal_register #(.WIDTH(W), .RESET_VALUE(4'h0)) dut0 (
        .clk(clk), .reset(rst0), .en(en0), .mode(mode0), .d(d0), .sin(sin0),
        .q(q0), .cout(cout0), .zero(zero0)
    );

    universal_register #(.WIDTH(W), .RESET_VALUE(4'h7)) dut1 (
        .clk(clk), .reset(rst1), .en(en1), .mode(mode1), .d(d1), .sin(sin1),
        .q(q1), .cout(cout1), .zero(zero1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one operation to the selected DUT; the other DUT is disabled.
    task automatic op(input int which, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dd, input logic s);
        @(negedge clk);
        if (which == 0) begin
            en0 = e; mode0 = m; d0 = dd; sin0 = s; en1 = 1'b0;
        end else begin
            en1 = e; mode1 = m; d1 = dd; sin1 = s; en0 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0; failed = 0;
        rst0 = 1'b0; en0 = 1'b0; mode0 = MODE_HOLD; d0 = '0; sin0 = 1'b0;
        rst1 = 1'b0; en1 = 1'b0; mode1 = MODE_HOLD; d1 = '0; sin1 = 1'b0;

        // Power-on reset
        #1; rst0 = 1'b1; rst1 = 1'b1;
        #1;
        chk("por_q0", q0, 4'h0);
        chk("por_cout0", cout0, 1'b0);
        chk("por_zero0", zero0, 1'b1);
        chk("por_q1", q1, 4'h7);
        chk("por_zero1", zero1, 1'b0);
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;

        // Asynchronous reset between edges with q = A
        op(0, 1'b1, MODE_LOAD, 4'hA, 1'b0);
        chk("load_a", q0, 4'hA);
        chk("load_a_zero", zero0, 1'b0);
        #2; rst0 = 1'b1;
        #1;
        chk("async_rst_q", q0, 4'h0);
        chk("async_rst_cout", cout0, 1'b0);
        chk("async_rst_zero", zero0, 1'b1);
        // Inputs ignored while reset is high
        @(negedge clk);
        en0 = 1'b1; mode0 = MODE_LOAD; d0 = 4'hF;
        @(posedge clk); #1;
        chk("rst_ignores_load", q0, 4'h0);
        // Release; first edge after release performs exactly one INC
        @(negedge clk);
        rst0 = 1'b0; en0 = 1'b1; mode0 = MODE_INC;
        @(posedge clk); #1;
        chk("release_inc", q0, 4'h1);

        // Increment wrap
        op(0, 1'b1, MODE_LOAD, 4'hE, 1'b0);
        chk("wrap_load", q0, 4'hE);
        op(0, 1'b1, MODE_INC, 4'h0, 1'b0);
        chk("inc1_q", q0, 4'hF);
        chk("inc1_cout", cout0, 1'b0);
        op(0, 1'b1, MODE_INC, 4'h0, 1'b0);
        chk("inc2_q", q0, 4'h0);
        chk("inc2_cout", cout0, 1'b1);
        chk("inc2_zero", zero0, 1'b1);
        op(0, 1'b1, MODE_LOAD, 4'h3, 1'b0);
        chk("load_clr_cout", cout0, 1'b0);

        // Decrement borrow
        op(0, 1'b1, MODE_CLEAR, 4'h0, 1'b0);
        chk("clear_q", q0, 4'h0);
        op(0, 1'b1, MODE_DEC, 4'h0, 1'b0);
        chk("dec1_q", q0, 4'hF);
        chk("dec1_cout", cout0, 1'b1);
        op(0, 1'b1, MODE_DEC, 4'h0, 1'b0);
        chk("dec2_q", q0, 4'hE);
        chk("dec2_cout", cout0, 1'b0);

        // Shift / rotate
        op(0, 1'b1, MODE_LOAD, 4'b1001, 1'b0);
        op(0, 1'b1, MODE_SHL, 4'h0, 1'b0);
        chk("shl_q", q0, 4'b0010);
        chk("shl_cout", cout0, 1'b1);
        op(0, 1'b1, MODE_SHR, 4'h0, 1'b1);
        chk("shr_q", q0, 4'b1001);
        chk("shr_cout", cout0, 1'b0);
        op(0, 1'b1, MODE_ROL, 4'h0, 1'b0);
        chk("rol_q", q0, 4'b0011);
        chk("rol_cout", cout0, 1'b1);

        // Enable low and HOLD (q = 3, cout = 1 going in)
        for (int i = 0; i < 3; i++) begin
            op(0, 1'b0, MODE_LOAD, 4'h5, 1'b0);
            chk("en_low_q", q0, 4'h3);
            chk("en_low_cout", cout0, 1'b1);
        end
        op(0, 1'b1, MODE_HOLD, 4'h5, 1'b1);
        chk("hold_q", q0, 4'h3);
        chk("hold_cout", cout0, 1'b1);

        // Non-zero reset value, reset pulsed during an INC run
        op(1, 1'b1, MODE_LOAD, 4'hF, 1'b0);
        chk("rv_load", q1, 4'hF);
        op(1, 1'b1, MODE_INC, 4'h0, 1'b0);
        chk("rv_inc_q", q1, 4'h0);
        chk("rv_inc_cout", cout1, 1'b1);
        #2; rst1 = 1'b1;
        #1;
        chk("rv_rst_q", q1, 4'h7);
        chk("rv_rst_cout", cout1, 1'b0);
        @(negedge clk);
        rst1 = 1'b0; en1 = 1'b1; mode1 = MODE_INC;
        @(posedge clk); #1;
        chk("rv_after_q", q1, 4'h8);
        chk("rv_after_cout", cout1, 1'b0);
        chk("dut0_idle", q0, 4'h3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_universal_register
